xnor_parity_scheduler: RTL
==========================

Name: xnor_parity_scheduler

Overview:
- Time-shares one XNOR-reduction accumulator among REQUESTERS clients. Each client submits multi-word frames.
- Round-robin arbitration happens at frame boundaries. The granted client streams words until its last word; the block then returns the 1-bit XNOR-chain result with the owner index.
- Sits between packet sources and the parity/check logic.

Parameters:
REQUESTERS, 4, number of client ports (2..16)
OWNER_WIDTH, 2, width of owner index; must satisfy 2**OWNER_WIDTH >= REQUESTERS
INPUT_WIDTH, 8, bits per data word
TIMEOUT_CYCLES, 16, stall limit for the optional watchdog (>=1)

Ports:
clock  input  1  rising-edge clock
resetN  input  1  synchronous active-low reset
requestValid  input  REQUESTERS  per-client word valid
requestLast  input  REQUESTERS  per-client last-word-of-frame flag
requestData  input  REQUESTERS*INPUT_WIDTH  packed words; client i at [i*INPUT_WIDTH +: INPUT_WIDTH]
requestReady  output  REQUESTERS  per-client accept; at most one bit high
resultValid  output  1  result available
resultData  output  1  frame XNOR-chain result
resultOwner  output  OWNER_WIDTH  client that produced the result
resultAbort  output  1  frame ended by watchdog (optional feature)
resultReady  input  1  consumer accepts result
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock. Reset is synchronous, active-low on resetN, sampled at the clock edge.
- State machine: IDLE, ACCUM, RESULT. All transitions are registered.
- Reset values:
  - state = IDLE.
  - requestReady = 0, resultValid = 0, resultData = 0, resultOwner = 0, resultAbort = 0, busy = 0.
  - Accumulator = 1.
  - RR pointer = REQUESTERS-1, so client 0 wins first.
- IDLE:
  - If any requestValid bit is high, grant the first valid client searching from pointer+1 upward, wrapping modulo REQUESTERS.
  - Register the owner, set accumulator = 1, go to ACCUM next cycle.
  - One arbitration cycle per frame.
- ACCUM:
  - requestReady[owner] = requestValid-independent 1. All other requestReady bits are 0.
  - A word is accepted when requestValid[owner] & requestReady[owner].
  - Accepted word: accumulator <= XNOR chain seeded with the accumulator over bits 0..INPUT_WIDTH-1. This equals acc ^ (^data) ^ INPUT_WIDTH[0].
  - Owner dropping valid mid-frame is a legal stall: no state change.
  - Accepted word with requestLast[owner]=1: go to RESULT.
- RESULT:
  - resultValid = 1, resultData = final accumulator, resultOwner = owner. All three are stable until handshake.
  - Latency: last word accepted at edge T gives resultValid high after edge T+1.
  - On resultValid & resultReady: go to IDLE, pointer <= owner, resultValid <= 0.
- Boundary rules:
  - Non-owner valids are ignored during ACCUM and RESULT.
  - resultReady outside RESULT is ignored.
  - Single-word frame (valid & last on the first beat) is legal.
  - Only one requester valid: it is re-granted every frame, with one IDLE cycle between frames.
  - requestLast is sampled only on an accepted beat.
  - resetN low mid-frame or mid-result: frame dropped, no result emitted, return to reset values.
  - With INPUT_WIDTH=8, per word acc' = acc ^ parity(data).

Optional Feature:
- Macro: XNOR_PARITY_SCHEDULER_TIMEOUT_EN.
- Defined:
  - In ACCUM, a counter increments each cycle requestValid[owner] is 0 and clears on any accepted word.
  - When the counter reaches TIMEOUT_CYCLES, abort the frame: go to RESULT with resultAbort = 1 and resultData = current accumulator.
  - resultAbort clears when the result handshake completes.
- Undefined: no counter; resultAbort is tied to 0; the owner may stall indefinitely.

Test Plan:
- Reset, then client 2 sends 0xFF (last=1): grant in 1 cycle; resultValid 1 cycle after the beat; resultData=1, resultOwner=2; busy high from grant through handshake.
- Client 0 sends 0x01, 0x03, 0x80 (last on 0x80): acc steps 1→0→0→1; resultData=1, resultOwner=0; requestReady never high for clients 1..3.
- All four clients hold valid with single-word frames, resultReady=1: grant order 0,1,2,3,0; one IDLE cycle between frames.
- Hold resultReady=0 for 5 cycles in RESULT while other clients are valid: resultData and resultOwner stable, no new grant, no requestReady; release → next client granted in IDLE.
- Client 1 stalls 3 cycles mid-frame, then completes: result matches the unstalled run. Separately, assert resetN=0 mid-frame: no resultValid, and client 0 is granted first after release.
- Macro defined, TIMEOUT_CYCLES=16: client 3 sends 0x07 then drops valid for 16 cycles → resultValid with resultAbort=1, resultData=0, resultOwner=3. Macro undefined: the same stimulus stays in ACCUM with resultAbort=0.

Source files
------------

// File: rtl/xnor_parity_scheduler_if.sv
// Client/result bundle for xnor_parity_scheduler: per-client word streams in,
// one frame result (plus busy status) out.
interface xnor_parity_scheduler_if #(
    parameter int unsigned REQUESTERS  = 4,
    parameter int unsigned OWNER_WIDTH = 2,
    parameter int unsigned INPUT_WIDTH = 8
);
    logic [REQUESTERS-1:0]             requestValid;
    logic [REQUESTERS-1:0]             requestLast;
    logic [REQUESTERS*INPUT_WIDTH-1:0] requestData;
    logic [REQUESTERS-1:0]             requestReady;
    logic                              resultValid;
    logic                              resultData;
    logic [OWNER_WIDTH-1:0]            resultOwner;
    logic                              resultAbort;
    logic                              resultReady;
    logic                              busy;

    modport master (
        output requestValid, requestLast, requestData, resultReady,
        input  requestReady, resultValid, resultData, resultOwner, resultAbort, busy
    );

    modport slave (
        input  requestValid, requestLast, requestData, resultReady,
        output requestReady, resultValid, resultData, resultOwner, resultAbort, busy
    );
endinterface

// File: rtl/xnor_parity_scheduler.sv
// Round-robin frame scheduler sharing one XNOR-chain accumulator among clients.
// Optional stall watchdog enabled by defining XNOR_PARITY_SCHEDULER_TIMEOUT_EN.
module xnor_parity_scheduler #(
    parameter int unsigned REQUESTERS     = 4,
    parameter int unsigned OWNER_WIDTH    = 2,
    parameter int unsigned INPUT_WIDTH    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic                    clock,
    input logic                    resetN,
    xnor_parity_scheduler_if.slave bus
);

    localparam int unsigned NPAD      = 1 << OWNER_WIDTH;
    localparam logic        WIDTH_ODD = 1'(INPUT_WIDTH % 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        RESULT = 2'd2
    } state_e;

    state_e                  state_q;
    logic [REQUESTERS-1:0]   ready_q;
    logic                    result_valid_q;
    logic                    result_data_q;
    logic [OWNER_WIDTH-1:0]  result_owner_q;
    logic                    busy_q;
    logic                    acc_q;
    logic [OWNER_WIDTH-1:0]  owner_q;
    logic [OWNER_WIDTH-1:0]  ptr_q;

    logic [NPAD-1:0]         valid_pad;
    logic [INPUT_WIDTH-1:0]  words [NPAD];
    logic                    grant_found_d;
    logic [OWNER_WIDTH-1:0]  grant_idx_d;
    logic [REQUESTERS-1:0]   grant_onehot_d;
    logic                    accept_d;
    logic                    last_d;
    logic                    acc_d;

`ifdef XNOR_PARITY_SCHEDULER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] stall_cnt_q;
    logic             abort_pend_q;
    logic             abort_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Pad client words to a power-of-two table so owner_q indexes it directly.
    for (genvar g = 0; g < NPAD; g++) begin : g_words
        if (g < REQUESTERS) begin : g_used
            assign words[g] = bus.requestData[g*INPUT_WIDTH +: INPUT_WIDTH];
        end else begin : g_pad
            assign words[g] = '0;
        end
    end

    assign valid_pad = NPAD'(bus.requestValid);

    // Round-robin search starting just after the last served client.
    always_comb begin
        logic [OWNER_WIDTH-1:0] cand;
        grant_found_d = 1'b0;
        grant_idx_d   = '0;
        cand          = '0;
        for (int unsigned k = 1; k <= REQUESTERS; k++) begin
            cand = OWNER_WIDTH'((32'(ptr_q) + k) % REQUESTERS);
            if (!grant_found_d && valid_pad[cand]) begin
                grant_found_d = 1'b1;
                grant_idx_d   = cand;
            end
        end
        grant_onehot_d = REQUESTERS'(NPAD'(1) << grant_idx_d);
    end

    // ready_q is one-hot on the owner only while accumulating.
    assign accept_d = |(ready_q & bus.requestValid);
    assign last_d   = |(ready_q & bus.requestLast);
    assign acc_d    = acc_q ^ (^words[owner_q]) ^ WIDTH_ODD;

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q        <= IDLE;
            ready_q        <= '0;
            result_valid_q <= 1'b0;
            result_data_q  <= 1'b0;
            result_owner_q <= '0;
            busy_q         <= 1'b0;
            acc_q          <= 1'b1;
            owner_q        <= '0;
            ptr_q          <= OWNER_WIDTH'(REQUESTERS - 1);
`ifdef XNOR_PARITY_SCHEDULER_TIMEOUT_EN
            stall_cnt_q    <= '0;
            abort_pend_q   <= 1'b0;
            abort_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found_d) begin
                        owner_q <= grant_idx_d;
                        ready_q <= grant_onehot_d;
                        acc_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ACCUM;
`ifdef XNOR_PARITY_SCHEDULER_TIMEOUT_EN
                        stall_cnt_q <= '0;
`endif
                    end
                end
                ACCUM: begin
                    if (accept_d) begin
                        acc_q <= acc_d;
`ifdef XNOR_PARITY_SCHEDULER_TIMEOUT_EN
                        stall_cnt_q <= '0;
`endif
                        if (last_d) begin
                            ready_q <= '0;
                            state_q <= RESULT;
                        end
                    end
`ifdef XNOR_PARITY_SCHEDULER_TIMEOUT_EN
                    // Owner idle too long: close the frame with what was accumulated.
                    else if (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        ready_q      <= '0;
                        abort_pend_q <= 1'b1;
                        state_q      <= RESULT;
                    end else begin
                        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                    end
`endif
                end
                RESULT: begin
                    if (!result_valid_q) begin
                        result_valid_q <= 1'b1;
                        result_data_q  <= acc_q;
                        result_owner_q <= owner_q;
`ifdef XNOR_PARITY_SCHEDULER_TIMEOUT_EN
                        abort_q        <= abort_pend_q;
`endif
                    end else if (bus.resultReady) begin
                        result_valid_q <= 1'b0;
                        ptr_q          <= owner_q;
                        busy_q         <= 1'b0;
                        state_q        <= IDLE;
`ifdef XNOR_PARITY_SCHEDULER_TIMEOUT_EN
                        abort_pend_q   <= 1'b0;
                        abort_q        <= 1'b0;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.requestReady = ready_q;
    assign bus.resultValid  = result_valid_q;
    assign bus.resultData   = result_data_q;
    assign bus.resultOwner  = result_owner_q;
    assign bus.busy         = busy_q;
`ifdef XNOR_PARITY_SCHEDULER_TIMEOUT_EN
    assign bus.resultAbort  = abort_q;
`else
    assign bus.resultAbort  = 1'b0;
`endif

endmodule
